// File: rtl/jk_reg_driver.sv
// jk_reg_driver: command controller that sources J/K for a bank of JK flip-flops,
// waits for the bank to settle and verifies its Q outputs against the expected value.
// Optional feature: define JKDRV_ERR_COUNT_EN to add an 8-bit saturating err_count output.
module jk_reg_driver #(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_data,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] q_fb,
   output logic             busy,
   output logic             done,
   output logic             err
`ifdef JKDRV_ERR_COUNT_EN
   ,
   output logic [7:0]       err_count
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SETTLE = 2'd2,
      CHECK  = 2'd3
   } state_t;

   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_SET    = 2'b01;
   localparam logic [1:0] OP_CLEAR  = 2'b10;
   localparam logic [1:0] OP_TOGGLE = 2'b11;

   // The counter runs SETTLE_CYCLES-1 down to 0, so SETTLE lasts SETTLE_CYCLES edges.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] j_q, j_d;
   logic [WIDTH-1:0] k_q, k_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             ready_q, ready_d;
   logic             accept;

   // Next-state, excitation and registered-output logic.
   always_comb begin
      state_d = state_q;
      j_d     = '0;
      k_d     = '0;
      exp_d   = exp_q;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      ready_d = 1'b0;
      // ready_q is only ever high in IDLE and CHECK, so it alone qualifies acceptance.
      accept  = req_valid && ready_q;

      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
         end
         DRIVE: begin
            state_d = SETTLE;
            cnt_d   = SETTLE_LOAD;
            busy_d  = 1'b1;
         end
         SETTLE: begin
            if (cnt_q == 4'd0) begin
               state_d = CHECK;
               done_d  = 1'b1;
               err_d   = (q_fb != exp_q);
               ready_d = 1'b1;
            end else begin
               cnt_d  = cnt_q - 4'd1;
               busy_d = 1'b1;
            end
         end
         CHECK: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Acceptance overrides the IDLE/CHECK defaults so back-to-back commands lose no cycle.
      if (accept) begin
         state_d = DRIVE;
         busy_d  = 1'b1;
         ready_d = 1'b0;
         case (req_op)
            OP_LOAD: begin
               // Only bits that differ get excited; correct bits are held.
               j_d   = req_data & ~q_fb;
               k_d   = ~req_data & q_fb;
               exp_d = req_data;
            end
            OP_SET: begin
               j_d   = req_data;
               exp_d = q_fb | req_data;
            end
            OP_CLEAR: begin
               k_d   = req_data;
               exp_d = q_fb & ~req_data;
            end
            OP_TOGGLE: begin
               j_d   = req_data;
               k_d   = req_data;
               exp_d = q_fb ^ req_data;
            end
            default: begin
               exp_d = q_fb;
            end
         endcase
      end
   end

   // Control and output registers; reset aborts any command in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         j_q     <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ready_q <= ready_d;
      end
   end

   // Expected Q value; only meaningful while a command is in flight, so no reset.
   always_ff @(posedge clk) begin
      exp_q <= exp_d;
   end

   assign j         = j_q;
   assign k         = k_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign req_ready = ready_q;

`ifdef JKDRV_ERR_COUNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Saturating count of err pulses, advanced on the edge that raises err.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // Error counter register, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_jk_reg_driver.sv
// Randomized self-checking bench for jk_reg_driver with a JK flip-flop bank model.
module tb_jk_reg_driver;

   localparam int W      = 8;
   localparam int SETTLE = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [1:0]   req_op = 2'b00;
   logic [W-1:0] req_data = '0;
   logic [W-1:0] j, k, q_fb;
   logic         busy, done, err;
`ifdef JKDRV_ERR_COUNT_EN
   logic [7:0]   err_count;
`endif

   logic [W-1:0] bank = '0;
   logic [W-1:0] bank_val = '0;
   logic         bank_load = 1'b0;
   logic         stuck = 1'b0;

   int checks = 0;
   int errors = 0;
   int ecnt   = 0;

   jk_reg_driver #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_data  (req_data),
      .j         (j),
      .k         (k),
      .q_fb      (q_fb),
      .busy      (busy),
      .done      (done),
      .err       (err)
`ifdef JKDRV_ERR_COUNT_EN
      ,
      .err_count (err_count)
`endif
   );

   always #5 clk = ~clk;

   // Flip-flop bank: JK next-state rule, optionally stuck, or preloaded by the bench.
   always @(posedge clk) begin
      if (bank_load)   bank <= bank_val;
      else if (!stuck) bank <= (j & ~bank) | (~k & bank);
   end
   assign q_fb = bank;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, expv, $time);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_j"}, 32'(j), 32'd0);
      chk({tag, "_k"}, 32'(k), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_rdy"}, 32'(req_ready), 32'd0);
`ifdef JKDRV_ERR_COUNT_EN
      chk({tag, "_ecnt"}, 32'(err_count), 32'd0);
`endif
   endtask

   task automatic load_bank(input logic [W-1:0] v);
      bank_val  = v;
      bank_load = 1'b1;
      @(posedge clk); #1;
      bank_load = 1'b0;
   endtask

   task automatic idle_gap(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         chk("idle_done", 32'(done), 32'd0);
         chk("idle_rdy", 32'(req_ready), 32'd1);
      end
   endtask

   // Issue one command at a point where req_ready is high and follow it to completion
   // (or, with abort set, reset the block while it is settling).
   task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] data,
                          input bit stk, input bit abort);
      logic [W-1:0] q0, ej, ek, ee;
      bit           eerr;
      q0 = bank;
      case (op)
         2'b00:   begin ej = data & ~q0; ek = ~data & q0; ee = data;      end
         2'b01:   begin ej = data;       ek = '0;         ee = q0 | data; end
         2'b10:   begin ej = '0;         ek = data;       ee = q0 & ~data; end
         default: begin ej = data;       ek = data;       ee = q0 ^ data; end
      endcase
      // A stuck bank never changes, so the check sees the snapshot value.
      eerr = stk && (q0 != ee);

      chk("pre_rdy", 32'(req_ready), 32'd1);
      stuck     = stk;
      req_op    = op;
      req_data  = data;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_op    = 2'($urandom);
      req_data  = W'($urandom);
      chk("drv_j", 32'(j), 32'(ej));
      chk("drv_k", 32'(k), 32'(ek));
      chk("drv_busy", 32'(busy), 32'd1);
      chk("drv_rdy", 32'(req_ready), 32'd0);
      chk("drv_done", 32'(done), 32'd0);

      @(posedge clk); #1;
      chk("set_j", 32'(j), 32'd0);
      chk("set_k", 32'(k), 32'd0);
      chk("set_busy", 32'(busy), 32'd1);
      chk("set_done", 32'(done), 32'd0);

      if (abort) begin
         rst = 1'b0;
         @(posedge clk); #1;
         chk_reset_outputs("abort");
         rst  = 1'b1;
         ecnt = 0;
         @(posedge clk); #1;
         chk("abort_rel_rdy", 32'(req_ready), 32'd1);
         chk("abort_rel_done", 32'(done), 32'd0);
         chk("abort_rel_busy", 32'(busy), 32'd0);
      end else begin
         repeat (SETTLE - 1) begin
            @(posedge clk); #1;
            chk("wait_done", 32'(done), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
         end
         @(posedge clk); #1;
         chk("chk_done", 32'(done), 32'd1);
         chk("chk_err", 32'(err), 32'(eerr));
         chk("chk_busy", 32'(busy), 32'd0);
         chk("chk_rdy", 32'(req_ready), 32'd1);
         chk("chk_j", 32'(j), 32'd0);
         if (eerr && ecnt < 255) ecnt++;
`ifdef JKDRV_ERR_COUNT_EN
         chk("err_count", 32'(err_count), 32'(ecnt));
`endif
      end
      stuck = 1'b0;
   endtask

   initial begin
      // Reset held with a request pending: nothing may be accepted.
      rst       = 1'b0;
      req_valid = 1'b1;
      req_op    = 2'b00;
      req_data  = 8'hFF;
      repeat (2) begin
         @(posedge clk); #1;
         chk_reset_outputs("rst");
      end
      rst = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rel_rdy", 32'(req_ready), 32'd1);
      chk("rel_busy", 32'(busy), 32'd0);
      chk("rel_j", 32'(j), 32'd0);
      chk("rel_q", 32'(q_fb), 32'd0);

      // LOAD A5 over 0F.
      load_bank(8'h0F);
      run_cmd(2'b00, 8'hA5, 1'b0, 1'b0);
      chk("load_q", 32'(q_fb), 32'hA5);

      // TOGGLE all bits of 3C.
      load_bank(8'h3C);
      run_cmd(2'b11, 8'hFF, 1'b0, 1'b0);
      chk("toggle_q", 32'(q_fb), 32'hC3);

      // SET bit 0 against a bank stuck at 00, back-to-back until the counter saturates.
      load_bank(8'h00);
      for (int i = 0; i < 300; i++) run_cmd(2'b01, 8'h01, 1'b1, 1'b0);

      // Back-to-back CLEAR then LOAD, the second accepted in the done cycle.
      load_bank(8'hFF);
      run_cmd(2'b10, 8'hF0, 1'b0, 1'b0);
      run_cmd(2'b00, 8'h55, 1'b0, 1'b0);
      chk("b2b_q", 32'(q_fb), 32'h55);
      idle_gap(1);

      // Reset while settling, then a normal LOAD.
      load_bank(8'h81);
      run_cmd(2'b10, 8'h80, 1'b0, 1'b1);
      run_cmd(2'b00, 8'h3A, 1'b0, 1'b0);
      chk("post_abort_q", 32'(q_fb), 32'h3A);

      // Randomized commands, preloads, stuck banks and idle gaps.
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 2) == 0) load_bank(W'($urandom));
         idle_gap(int'($urandom_range(0, 2)));
         run_cmd(2'($urandom), W'($urandom), ($urandom_range(0, 4) == 0), 1'b0);
      end
      idle_gap(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
